nios_system_tec2_timer_svc: RTL and testbench

//  Avalon-MM master that programs and services the system interval timer without CPU involvement.
//  On cfg_start it writes the period and control registers.
//  On each timer irq it clears the status register, triggers a snapshot and reads both snapshot halves.
//  It presents the 32-bit snapshot plus a running event count to the fabric.

---
 rtl/nios_system_tec2_timer_svc.sv | 188 ++++++++++++++++++
 tb/tb_nios_system_tec2_timer_svc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_tec2_timer_svc.sv
// Avalon-MM master that programs the interval timer and services each irq (snapshot + event count); optional TIMER_SVC_OVERRUN_EN adds a sticky overrun flag.
// Latency: one bus transfer per FSM state, >=1 idle cycle between transfers, read data captured READ_LATENCY cycles after accept.
// Backpressure: m_waitrequest stalls the current transfer with all m_* held stable; cfg_start is ignored while busy.
module nios_system_tec2_timer_svc #(
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_period,
    input  logic             cfg_continuous,
    input  logic             irq,
    output logic [2:0]       m_address,
    output logic             m_chipselect,
    output logic             m_write_n,
    output logic [15:0]      m_writedata,
    input  logic [15:0]      m_readdata,
    input  logic             m_waitrequest,
    output logic [31:0]      snap_value,
    output logic             snap_valid,
    output logic [CNT_W-1:0] event_count,
    output logic             busy
`ifdef TIMER_SVC_OVERRUN_EN
    ,
    output logic             overrun
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_W_PL, S_W_PH, S_W_CTL, S_WAIT_IRQ, S_W_ST, S_W_SN,
        S_R_L, S_R_L_LAT, S_R_H, S_R_H_LAT, S_DONE
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(READ_LATENCY - 1);

    state_t      state, state_n;
    logic        gap;
    logic [1:0]  lat_cnt;
    logic [31:0] period_q;
    logic        cont_q;
    logic [15:0] snap_lo_q;
    logic        is_bus;
    logic        accept;
    logic        start_acc;
    logic        capture_lo;
    logic        capture_hi;

    // Bus outputs are decoded from state so an async reset drops chipselect at once.
    assign is_bus       = state inside {S_W_PL, S_W_PH, S_W_CTL, S_W_ST, S_W_SN, S_R_L, S_R_H};
    assign m_chipselect = is_bus && !gap;
    assign accept       = m_chipselect && !m_waitrequest;
    assign snap_valid   = (state == S_DONE);
    assign busy         = !(state == S_IDLE || state == S_WAIT_IRQ);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        m_address   = 3'd0;
        m_write_n   = 1'b1;
        m_writedata = 16'h0000;
        start_acc   = 1'b0;
        capture_lo  = 1'b0;
        capture_hi  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    start_acc = 1'b1;
                    state_n   = S_W_PL;
                end
            end
            S_W_PL: begin
                m_address   = 3'd2;
                m_write_n   = 1'b0;
                m_writedata = period_q[15:0];
                if (accept) state_n = S_W_PH;
            end
            S_W_PH: begin
                m_address   = 3'd3;
                m_write_n   = 1'b0;
                m_writedata = period_q[31:16];
                if (accept) state_n = S_W_CTL;
            end
            S_W_CTL: begin
                // STOP=0, START=1, CONT, ITO=1
                m_address   = 3'd1;
                m_write_n   = 1'b0;
                m_writedata = {12'h000, 1'b0, 1'b1, cont_q, 1'b1};
                if (accept) state_n = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                if (cfg_start) begin
                    start_acc = 1'b1;
                    state_n   = S_W_PL;
                end else if (irq) begin
                    state_n = S_W_ST;
                end
            end
            S_W_ST: begin
                m_address = 3'd0;
                m_write_n = 1'b0;
                if (accept) state_n = S_W_SN;
            end
            S_W_SN: begin
                m_address = 3'd4;
                m_write_n = 1'b0;
                if (accept) state_n = S_R_L;
            end
            S_R_L: begin
                m_address = 3'd4;
                if (accept) state_n = S_R_L_LAT;
            end
            S_R_L_LAT: begin
                if (lat_cnt == 2'd0) begin
                    capture_lo = 1'b1;
                    state_n    = S_R_H;
                end
            end
            S_R_H: begin
                m_address = 3'd5;
                if (accept) state_n = S_R_H_LAT;
            end
            S_R_H_LAT: begin
                if (lat_cnt == 2'd0) begin
                    capture_hi = 1'b1;
                    state_n    = S_DONE;
                end
            end
            S_DONE: begin
                state_n = cont_q ? S_WAIT_IRQ : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gap         <= 1'b0;
            lat_cnt     <= 2'd0;
            period_q    <= 32'h0;
            cont_q      <= 1'b0;
            snap_lo_q   <= 16'h0;
            snap_value  <= 32'h0;
            event_count <= '0;
        end else begin
            // gap forces the idle cycle between back-to-back transfers
            gap <= accept;
            if (accept) begin
                lat_cnt <= LAT_INIT;
            end else if (lat_cnt != 2'd0) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
            if (start_acc) begin
                period_q    <= cfg_period;
                cont_q      <= cfg_continuous;
                event_count <= '0;
            end
            if (capture_lo) begin
                snap_lo_q <= m_readdata;
            end
            // Both halves land together so snap_value is never half-updated
            if (capture_hi) begin
                snap_value  <= {m_readdata, snap_lo_q};
                event_count <= event_count + CNT_W'(1);
            end
        end
    end

`ifdef TIMER_SVC_OVERRUN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (start_acc) begin
            overrun <= 1'b0;
        end else if (state == S_R_H_LAT && irq) begin
            overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nios_system_tec2_timer_svc.sv
// Scoreboard bench for nios_system_tec2_timer_svc: expected bus transfers and snapshots queued by stimulus, checked by a monitor.
module tb_nios_system_tec2_timer_svc;
    localparam int RL    = 1;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cfg_start = 1'b0;
    logic [31:0]      cfg_period = 32'h0;
    logic             cfg_continuous = 1'b0;
    logic             irq = 1'b0;
    logic [2:0]       m_address;
    logic             m_chipselect;
    logic             m_write_n;
    logic [15:0]      m_writedata;
    logic [15:0]      m_readdata = 16'hDEAD;
    logic             m_waitrequest = 1'b0;
    logic [31:0]      snap_value;
    logic             snap_valid;
    logic [CNT_W-1:0] event_count;
    logic             busy;

    nios_system_tec2_timer_svc #(.READ_LATENCY(RL), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .irq(irq), .m_address(m_address),
        .m_chipselect(m_chipselect), .m_write_n(m_write_n), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest), .snap_value(snap_value),
        .snap_valid(snap_valid), .event_count(event_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2:0] addr; logic wn; logic [15:0] wd; } bus_t;
    typedef struct { logic [31:0] v; logic [15:0] c; } snap_t;
    bus_t  exp_bus[$];
    snap_t exp_snap[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_stall  = 0;
    int stall_left = 0;
    logic [2:0]  stall_addr = 3'd0;
    logic        stall_wn = 1'b0;
    logic [15:0] snap_l = 16'h0;
    logic [15:0] snap_h = 16'h0;
    int          pend = 0;
    logic [15:0] pdata = 16'h0;
    logic        sv_chk = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_w(input logic [2:0] a, input logic [15:0] d);
        bus_t t;
        t.addr = a; t.wn = 1'b0; t.wd = d;
        exp_bus.push_back(t);
    endtask

    task automatic exp_r(input logic [2:0] a);
        bus_t t;
        t.addr = a; t.wn = 1'b1; t.wd = 16'h0;
        exp_bus.push_back(t);
    endtask

    task automatic exp_service(input logic [31:0] v, input logic [15:0] c);
        snap_t s;
        exp_w(3'd0, 16'h0000);
        exp_w(3'd4, 16'h0000);
        exp_r(3'd4);
        exp_r(3'd5);
        s.v = v; s.c = c;
        exp_snap.push_back(s);
    endtask

    task automatic wait_drain(input int budget, input string nm);
        for (int i = 0; i < budget && (exp_bus.size() > 0 || exp_snap.size() > 0); i++)
            @(negedge clk);
        chk({nm, " queues drained"}, 64'(exp_bus.size() + exp_snap.size()), 64'd0);
    endtask

    task automatic pulse_irq();
        @(negedge clk) irq = 1'b1;
        @(negedge clk) irq = 1'b0;
    endtask

    // Slave: read data valid RL cycles after accept, garbage otherwise; scripted waitrequest stalls.
    initial forever begin
        @(posedge clk);
        #1;
        if (pend > 0) begin
            pend--;
            m_readdata = (pend == 0) ? pdata : 16'hDEAD;
        end else begin
            m_readdata = 16'hDEAD;
        end
        m_waitrequest = 1'b0;
        if (m_chipselect && stall_left > 0 && m_address == stall_addr && m_write_n == stall_wn) begin
            m_waitrequest = 1'b1;
            stall_left--;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n && m_chipselect && !m_waitrequest && m_write_n) begin
            pend  = RL;
            pdata = (m_address == 3'd4) ? snap_l : snap_h;
        end
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (sv_chk) chk("snap_valid one cycle", 64'(snap_valid), 64'd0);
        sv_chk = snap_valid;
        if (m_chipselect) chk("busy during xfer", 64'(busy), 64'd1);
        if (m_chipselect && m_waitrequest) begin
            if (m_address == 3'd3) n_stall++;
            if (exp_bus.size() > 0) begin
                chk("stall addr stable", 64'(m_address), 64'(exp_bus[0].addr));
                if (!exp_bus[0].wn) chk("stall data stable", 64'(m_writedata), 64'(exp_bus[0].wd));
            end
        end
        if (m_chipselect && !m_waitrequest) begin
            if (exp_bus.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected bus xfer: addr %0d write_n %0b data %0h, none expected",
                         m_address, m_write_n, m_writedata);
            end else begin
                bus_t e;
                e = exp_bus.pop_front();
                chk("xfer addr", 64'(m_address), 64'(e.addr));
                chk("xfer write_n", 64'(m_write_n), 64'(e.wn));
                if (!e.wn) chk("xfer wdata", 64'(m_writedata), 64'(e.wd));
            end
        end
        if (snap_valid) begin
            if (exp_snap.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected snap_valid: value %0h count %0d, none expected", snap_value, event_count);
            end else begin
                snap_t s;
                s = exp_snap.pop_front();
                chk("snap_value", 64'(snap_value), 64'(s.v));
                chk("event_count at snap", 64'(event_count), 64'(s.c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit found;
        #12;
        chk("rst chipselect", 64'(m_chipselect), 64'd0);
        chk("rst write_n", 64'(m_write_n), 64'd1);
        chk("rst address", 64'(m_address), 64'd0);
        chk("rst writedata", 64'(m_writedata), 64'd0);
        chk("rst snap_value", 64'(snap_value), 64'd0);
        chk("rst snap_valid", 64'(snap_valid), 64'd0);
        chk("rst event_count", 64'(event_count), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        @(negedge clk) reset_n = 1'b1;

        // Program continuous mode with a 5-cycle stall on the period-high write
        stall_addr = 3'd3; stall_wn = 1'b0; stall_left = 5;
        exp_w(3'd2, 16'h86A0);
        exp_w(3'd3, 16'h0001);
        exp_w(3'd1, 16'h0007);
        @(negedge clk);
        cfg_period = 32'h0001_86A0; cfg_continuous = 1'b1; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0; cfg_period = 32'hFFFF_FFFF; cfg_continuous = 1'b0;
        wait_drain(100, "program");
        repeat (3) @(negedge clk);
        chk("busy in WAIT_IRQ", 64'(busy), 64'd0);
        chk("stall cycles on perh", 64'(n_stall), 64'd5);

        // First serviced event
        snap_l = 16'h1234; snap_h = 16'h0056;
        exp_service(32'h0056_1234, 16'd1);
        pulse_irq();
        wait_drain(100, "event1");
        repeat (3) @(negedge clk);
        chk("busy after event1", 64'(busy), 64'd0);
        chk("event_count after event1", 64'(event_count), 64'd1);

        // Second event; a cfg_start arriving mid-service must be ignored
        snap_l = 16'hBEEF; snap_h = 16'hCAFE;
        exp_service(32'hCAFE_BEEF, 16'd2);
        @(negedge clk) irq = 1'b1;
        @(negedge clk) irq = 1'b0; cfg_start = 1'b1; cfg_period = 32'h0BAD_0BAD;
        @(negedge clk) cfg_start = 1'b0;
        wait_drain(100, "event2");
        repeat (3) @(negedge clk);
        chk("busy after event2", 64'(busy), 64'd0);

        // cfg_start and irq together in WAIT_IRQ: reprogram wins, count clears
        exp_w(3'd2, 16'h5678);
        exp_w(3'd3, 16'h1234);
        exp_w(3'd1, 16'h0005);
        @(negedge clk);
        cfg_period = 32'h1234_5678; cfg_continuous = 1'b0; cfg_start = 1'b1; irq = 1'b1;
        @(negedge clk) cfg_start = 1'b0; irq = 1'b0;
        wait_drain(100, "reprogram");
        repeat (3) @(negedge clk);
        chk("event_count cleared", 64'(event_count), 64'd0);
        chk("busy after reprogram", 64'(busy), 64'd0);

        // One-shot event, then irq in IDLE must cause no traffic
        snap_l = 16'h0003; snap_h = 16'h0002;
        exp_service(32'h0002_0003, 16'd1);
        pulse_irq();
        wait_drain(100, "oneshot");
        @(negedge clk) irq = 1'b1;
        repeat (3) @(negedge clk);
        irq = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy idle after oneshot", 64'(busy), 64'd0);
        chk("event_count after oneshot", 64'(event_count), 64'd1);

        // Reset while the low snapshot read is stalled
        stall_addr = 3'd4; stall_wn = 1'b1; stall_left = 1000;
        exp_w(3'd2, 16'h0010);
        exp_w(3'd3, 16'h0000);
        exp_w(3'd1, 16'h0007);
        exp_w(3'd0, 16'h0000);
        exp_w(3'd4, 16'h0000);
        @(negedge clk);
        cfg_period = 32'h0000_0010; cfg_continuous = 1'b1; cfg_start = 1'b1;
        @(negedge clk) cfg_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = (exp_bus.size() == 2 && !busy);
        end
        chk("reached WAIT_IRQ before reset test", 64'(found), 64'd1);
        pulse_irq();
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = (m_chipselect && m_address == 3'd4 && m_write_n);
        end
        chk("reached R_L", 64'(found), 64'd1);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("mid-xfer rst chipselect", 64'(m_chipselect), 64'd0);
        chk("mid-xfer rst write_n", 64'(m_write_n), 64'd1);
        chk("mid-xfer rst address", 64'(m_address), 64'd0);
        chk("mid-xfer rst writedata", 64'(m_writedata), 64'd0);
        chk("mid-xfer rst busy", 64'(busy), 64'd0);
        chk("mid-xfer rst snap_value", 64'(snap_value), 64'd0);
        chk("mid-xfer rst snap_valid", 64'(snap_valid), 64'd0);
        chk("mid-xfer rst event_count", 64'(event_count), 64'd0);
        chk("bus queue before reset", 64'(exp_bus.size()), 64'd0);
        stall_left = 0;
        @(negedge clk) reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no traffic after reset", 64'(m_chipselect), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
